// File: rtl/ram_bank_writer_pkg.sv
// Bank geometry and AXI encodings shared by the bank writer and the bank readback block.
package ram_bank_writer_pkg;

  localparam int AXI_DW               = 512;
  localparam int CYCLES_PER_RAM_BLOCK = 64;
  localparam int RAM_BLOCKS_PER_BANK  = 32768;
  localparam int RAM_BLOCK_SIZE       = CYCLES_PER_RAM_BLOCK * AXI_DW / 8;

  localparam logic [1:0] AXI_BURST_INCR       = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY        = 2'b00;
  localparam logic [3:0] AXI_CACHE_MODIFIABLE = 4'b0010;
  localparam logic [2:0] AXI_PROT_NONSECURE   = 3'b010;

  typedef enum logic {AW_IDLE, AW_SEND} aw_state_t;
  typedef enum logic {W_IDLE, W_SEND} w_state_t;

  // Every 32-bit word carries its own word index within the bank fill.
  function automatic logic [31:0] pattern_word(input logic [31:0] beat,
                                               input logic [31:0] lanes,
                                               input logic [31:0] lane);
    return beat * lanes + lane;
  endfunction

endpackage

// File: rtl/ram_bank_writer_if.sv
// AXI4 memory-mapped bus between the bank writer (master) and the DDR controller (slave).
interface ram_bank_writer_if #(
  parameter int DW = 512
);
  logic [63:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [3:0]      awid;
  logic [1:0]      awburst;
  logic            awlock;
  logic [3:0]      awcache;
  logic [3:0]      awqos;
  logic [2:0]      awprot;
  logic            awvalid;
  logic            awready;

  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;

  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  logic [63:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [3:0]      arid;
  logic [1:0]      arburst;
  logic            arlock;
  logic [3:0]      arcache;
  logic [3:0]      arqos;
  logic [2:0]      arprot;
  logic            arvalid;
  logic            arready;

  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport master (
    output awaddr, awlen, awsize, awid, awburst, awlock, awcache, awqos, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arlen, arsize, arid, arburst, arlock, arcache, arqos, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awlen, awsize, awid, awburst, awlock, awcache, awqos, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arlen, arsize, arid, arburst, arlock, arcache, arqos, arprot, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready
  );

endinterface

// File: rtl/cdc_single.sv
// Two-flop synchroniser for a single slow control bit entering the clk domain.
module cdc_single (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/ram_bank_writer.sv
// AXI4 write master filling one DDR bank with self-indexing words; reports
// elapsed cycles and error responses of the last fill.
module ram_bank_writer
  import ram_bank_writer_pkg::*;
#(
  parameter int          DW        = AXI_DW,
  parameter int          BEATS     = CYCLES_PER_RAM_BLOCK,
  parameter int          BLOCKS    = RAM_BLOCKS_PER_BANK,
  parameter logic [63:0] BASE_ADDR = 64'h0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_async,
  output logic              idle,
  output logic [63:0]       elapsed,
  output logic [31:0]       errors,
  ram_bank_writer_if.master m_axi
);

  localparam int          LANES       = DW / 32;
  localparam logic [31:0] LANES_U     = 32'(LANES);
  localparam logic [63:0] BLOCK_BYTES = 64'(BEATS) * 64'(DW / 8);
  localparam logic [31:0] LAST_BLOCK  = 32'(BLOCKS - 1);
  localparam logic [7:0]  LAST_BEAT   = 8'(BEATS - 1);
  localparam logic [2:0]  AW_SIZE     = 3'($clog2(DW / 8));

  logic        start;
  logic        start_accept;
  logic        aw_hs;
  logic        w_hs;
  logic        wlast_hs;
  logic        b_hs;
  logic        awvalid;
  logic        wvalid;
  logic        wlast;
  logic [DW-1:0] wdata_pattern;

  logic        idle_reg, idle_next;
  logic [63:0] elapsed_reg, elapsed_next;
  logic [31:0] errors_reg, errors_next;
  logic [31:0] b_count_reg, b_count_next;

  aw_state_t   aw_state_reg, aw_state_next;
  logic [63:0] awaddr_reg, awaddr_next;
  logic [31:0] aw_count_reg, aw_count_next;

  w_state_t    w_state_reg, w_state_next;
  logic [31:0] w_count_reg, w_count_next;
  logic [31:0] credit_reg, credit_next;
  logic [31:0] beat_reg, beat_next;
  logic [7:0]  beat_in_burst_reg, beat_in_burst_next;

  cdc_single u_start_sync (
    .clk   (clk),
    .reset (reset),
    .d     (start_async),
    .q     (start)
  );

  assign start_accept = start & idle_reg;
  assign awvalid      = (aw_state_reg == AW_SEND);
  // credit_reg only counts AW handshakes from earlier edges, so W never leads AW.
  assign wvalid       = (w_state_reg == W_SEND) && (credit_reg != 32'd0);
  assign wlast        = (beat_in_burst_reg == LAST_BEAT);
  assign aw_hs        = awvalid & m_axi.awready;
  assign w_hs         = wvalid & m_axi.wready;
  assign wlast_hs     = w_hs & wlast;
  assign b_hs         = m_axi.bvalid & ~idle_reg;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign wdata_pattern[gi*32 +: 32] = pattern_word(beat_reg, LANES_U, 32'(gi));
    end
  endgenerate

  always_comb begin
    aw_state_next = aw_state_reg;
    awaddr_next   = awaddr_reg;
    aw_count_next = aw_count_reg;
    case (aw_state_reg)
      AW_IDLE: begin
        if (start_accept) begin
          aw_state_next = AW_SEND;
          awaddr_next   = BASE_ADDR;
          aw_count_next = 32'd0;
        end
      end
      AW_SEND: begin
        if (aw_hs) begin
          awaddr_next   = awaddr_reg + BLOCK_BYTES;
          aw_count_next = aw_count_reg + 32'd1;
          if (aw_count_reg == LAST_BLOCK) begin
            aw_state_next = AW_IDLE;
          end
        end
      end
      default: aw_state_next = AW_IDLE;
    endcase
  end

  always_comb begin
    w_state_next       = w_state_reg;
    w_count_next       = w_count_reg;
    beat_next          = beat_reg;
    beat_in_burst_next = beat_in_burst_reg;
    credit_next        = credit_reg + 32'(aw_hs) - 32'(wlast_hs);
    case (w_state_reg)
      W_IDLE: begin
        if (start_accept) begin
          w_state_next       = W_SEND;
          w_count_next       = 32'd0;
          beat_next          = 32'd0;
          beat_in_burst_next = 8'd0;
          credit_next        = 32'd0;
        end
      end
      W_SEND: begin
        if (w_hs) begin
          beat_next = beat_reg + 32'd1;
          if (wlast) begin
            beat_in_burst_next = 8'd0;
            w_count_next       = w_count_reg + 32'd1;
            if (w_count_reg == LAST_BLOCK) begin
              w_state_next = W_IDLE;
            end
          end else begin
            beat_in_burst_next = beat_in_burst_reg + 8'd1;
          end
        end
      end
      default: w_state_next = W_IDLE;
    endcase
  end

  always_comb begin
    idle_next    = idle_reg;
    elapsed_next = elapsed_reg;
    errors_next  = errors_reg;
    b_count_next = b_count_reg;
    if (idle_reg) begin
      if (start_accept) begin
        idle_next    = 1'b0;
        elapsed_next = 64'd0;
        errors_next  = 32'd0;
        b_count_next = 32'd0;
      end
    end else begin
      // The completing cycle is still counted before elapsed freezes.
      elapsed_next = elapsed_reg + 64'd1;
      if (b_hs) begin
        b_count_next = b_count_reg + 32'd1;
        if ((m_axi.bresp != AXI_RESP_OKAY) && (errors_reg != 32'hFFFF_FFFF)) begin
          errors_next = errors_reg + 32'd1;
        end
        if (b_count_reg == LAST_BLOCK) begin
          idle_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_reg          <= 1'b1;
      elapsed_reg       <= 64'd0;
      errors_reg        <= 32'd0;
      b_count_reg       <= 32'd0;
      aw_state_reg      <= AW_IDLE;
      awaddr_reg        <= 64'd0;
      aw_count_reg      <= 32'd0;
      w_state_reg       <= W_IDLE;
      w_count_reg       <= 32'd0;
      credit_reg        <= 32'd0;
      beat_reg          <= 32'd0;
      beat_in_burst_reg <= 8'd0;
    end else begin
      idle_reg          <= idle_next;
      elapsed_reg       <= elapsed_next;
      errors_reg        <= errors_next;
      b_count_reg       <= b_count_next;
      aw_state_reg      <= aw_state_next;
      awaddr_reg        <= awaddr_next;
      aw_count_reg      <= aw_count_next;
      w_state_reg       <= w_state_next;
      w_count_reg       <= w_count_next;
      credit_reg        <= credit_next;
      beat_reg          <= beat_next;
      beat_in_burst_reg <= beat_in_burst_next;
    end
  end

  assign idle    = idle_reg;
  assign elapsed = elapsed_reg;
  assign errors  = errors_reg;

  assign m_axi.awaddr  = awaddr_reg;
  assign m_axi.awlen   = LAST_BEAT;
  assign m_axi.awsize  = AW_SIZE;
  assign m_axi.awid    = 4'd0;
  assign m_axi.awburst = AXI_BURST_INCR;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = AXI_CACHE_MODIFIABLE;
  assign m_axi.awqos   = 4'd0;
  assign m_axi.awprot  = AXI_PROT_NONSECURE;
  assign m_axi.awvalid = awvalid;

  assign m_axi.wdata  = wdata_pattern;
  assign m_axi.wstrb  = '1;
  assign m_axi.wlast  = wlast;
  assign m_axi.wvalid = wvalid;
  assign m_axi.bready = 1'b1;

  // Write-only block: the read address and data channels are parked.
  assign m_axi.araddr  = 64'd0;
  assign m_axi.arlen   = 8'd0;
  assign m_axi.arsize  = 3'd0;
  assign m_axi.arid    = 4'd0;
  assign m_axi.arburst = 2'd0;
  assign m_axi.arlock  = 1'b0;
  assign m_axi.arcache = 4'd0;
  assign m_axi.arqos   = 4'd0;
  assign m_axi.arprot  = 3'd0;
  assign m_axi.arvalid = 1'b0;
  assign m_axi.rready  = 1'b0;

  logic unused_inputs;
  assign unused_inputs = ^{m_axi.arready, m_axi.rdata, m_axi.rresp, m_axi.rlast, m_axi.rvalid};

endmodule
